// File: rtl/aclk_disp_pkg.sv
// aclk_disp_pkg: shared segment/ASCII constants and digit-slot encoding
// for the alarm-clock display path.
package aclk_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {SLOT_MS_HR, SLOT_LS_HR, SLOT_MS_MIN, SLOT_LS_MIN} slot_t;
endpackage

// File: rtl/aclk_seg_decoder.sv
// aclk_seg_decoder: ASCII digit to active-low {g,f,e,d,c,b,a}; non-digits blank.
module aclk_seg_decoder
  import aclk_disp_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (ascii >= ASCII_ZERO && ascii <= ASCII_NINE)
      case (ascii[3:0])
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
  end
endmodule

// File: rtl/aclk_seg_scanner.sv
// aclk_seg_scanner: 4-digit multiplexed 7-segment driver with frame-latched
// digits, anti-ghost blanking, leading-zero suppression, colon and alarm flash.
module aclk_seg_scanner
  import aclk_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 64,
  parameter int BLANK_CYC   = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] display_time_ms_hr,
  input  logic [7:0] display_time_ls_hr,
  input  logic [7:0] display_time_ms_min,
  input  logic [7:0] display_time_ls_min,
  input  logic       sound_alarm,
  input  logic       one_second,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       buzzer
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] scan_cnt;
  slot_t         digit_idx;
  logic [7:0]    shadow [4];
  logic          phase;
  logic [7:0]    cur;
  logic [6:0]    dec_seg;
  logic          slot_end, frame_end, blank_win, flash, lz;
  assign slot_end  = scan_cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && digit_idx == SLOT_LS_MIN;
  assign cur       = shadow[digit_idx];
  assign blank_win = int'(scan_cnt) < BLANK_CYC;
  assign flash     = sound_alarm & phase;
  assign lz        = (LZ_SUPPRESS != 0) && digit_idx == SLOT_MS_HR && cur == ASCII_ZERO;
  aclk_seg_decoder u_dec (.ascii(cur), .seg(dec_seg));
  // Shadows load only at the frame boundary so a frame never mixes old and new time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= SLOT_MS_HR;
      phase     <= 1'b0;
      shadow    <= '{default: ASCII_SPACE};
      seg_n     <= SEG_BLANK;
      dp_n      <= 1'b1;
      an_n      <= 4'hF;
      buzzer    <= 1'b0;
    end else begin
      scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
      if (slot_end) digit_idx <= slot_t'(digit_idx + 2'd1);
      if (frame_end)
        shadow <= '{display_time_ms_hr, display_time_ls_hr, display_time_ms_min, display_time_ls_min};
      if (one_second) phase <= ~phase;
      seg_n  <= (flash || lz) ? SEG_BLANK : dec_seg;
      an_n   <= blank_win ? 4'hF : ~(4'b1000 >> digit_idx);
      dp_n   <= !(digit_idx == SLOT_LS_HR && !blank_win && !phase);
      buzzer <= sound_alarm & ~phase;
    end
  end
endmodule

// File: doc/aclk_seg_scanner.md
Name: aclk_seg_scanner

Overview:
- Downstream display stage of the alarm clock. It consumes the four ASCII digit codes (display_time_*) and sound_alarm produced by the clock top level.
- Drives a 4-digit common-anode multiplexed 7-segment LED module, a blinking colon and a gated buzzer.
- Provides tear-free frame capture, anti-ghost blanking, leading-zero suppression and alarm flashing.

Parameters:
SCAN_DIV, 64, clk cycles per digit slot; legal range >= 2.
BLANK_CYC, 2, cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.
LZ_SUPPRESS, 1, when 1, blank the hours-tens digit if it is '0'.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
display_time_ms_hr  in  8  ASCII hours tens (leftmost digit)
display_time_ls_hr  in  8  ASCII hours units
display_time_ms_min  in  8  ASCII minutes tens
display_time_ls_min  in  8  ASCII minutes units (rightmost digit)
sound_alarm  in  1  level, alarm active
one_second  in  1  single-cycle 1 Hz strobe
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  colon/decimal point, active-low
an_n  out  4  digit anodes, active-low; an_n[3] = leftmost digit
buzzer  out  1  buzzer enable, active-high

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high. Asserting reset mid-operation clears all state immediately.
- Reset values:
  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'hF, buzzer=0.
  - Internal: scan_cnt=0, digit_idx=0, phase=0, all shadow registers=8'h20 (blank).
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx advances 0->1->2->3->0. Slot 0 is ms_hr, slot 3 is ls_min.
  - One frame = 4*SCAN_DIV cycles.
- Frame capture (tear-free):
  - On the edge where scan_cnt==SCAN_DIV-1 and digit_idx==3, all four inputs load into the shadow registers.
  - Input changes at any other time are invisible until the next frame boundary.
  - The first frame after reset is displayed blank.
- Decode from shadow ASCII, active-low seg_n:
  - '0'..'9' (8'h30..8'h39) map to 40,79,24,30,19,12,02,78,00,10 (hex).
  - Any other code (e.g. 8'h20, 8'h41) maps to 7F.
- Leading zero: if LZ_SUPPRESS=1 and shadow ms_hr==8'h30, slot 0 decodes as 7F.
- Phase:
  - 1-bit phase toggles on each one_second strobe.
  - It is never cleared by sound_alarm changes; only reset clears it.
- Anodes:
  - During scan_cnt < BLANK_CYC, an_n=4'hF.
  - Otherwise an_n is all ones except bit (3-digit_idx), which is 0.
- Alarm flash: when sound_alarm=1 and phase=1, seg_n=7F and dp_n=1 for every slot; anodes keep scanning.
- Colon: dp_n=0 only in slot 1 (ls_hr), outside the blanking window, when phase=0. Otherwise dp_n=1.
- Buzzer: buzzer = sound_alarm & ~phase.
- Registration and latency:
  - All outputs are registered. Each is a function of the (scan_cnt, digit_idx, shadow, phase) state in the previous cycle, giving 1-cycle latency.
  - Shadow capture at the frame boundary is therefore visible from the first output cycle of the next slot 0.
- Simultaneous events:
  - one_second at the frame boundary: capture and toggle both take effect, and the next slot uses new data and new phase.
  - sound_alarm deasserting: takes effect on the next output cycle; the display resumes without waiting for a frame boundary.

Decomposition:
- Package aclk_disp_pkg:
  - SEG_BLANK (7'h7F) and the ten digit segment constants.
  - ASCII_ZERO (8'h30), ASCII_NINE (8'h39), ASCII_SPACE (8'h20).
  - Digit-slot enum {SLOT_MS_HR, SLOT_LS_HR, SLOT_MS_MIN, SLOT_LS_MIN}.
- Sub-module aclk_seg_decoder: combinational, 8-bit ASCII in, 7-bit active-low segments out, invalid codes map to blank.
- The scanner instantiates one aclk_seg_decoder on the muxed shadow byte.

Test Plan:
Bench parameters for all scenarios: SCAN_DIV=4, BLANK_CYC=1, LZ_SUPPRESS=1.
1. Reset, then hold inputs 8'h31,32,33,34 -> frame 1 has seg_n=7F in all slots. In frame 2, each slot shows 1 cycle an_n=F followed by 3 cycles of:
   - slot 0: an_n=0111, seg_n=79
   - slot 1: an_n=1011, seg_n=24
   - slot 2: an_n=1101, seg_n=30
   - slot 3: an_n=1110, seg_n=19
2. Inputs "0930" (8'h30,39,33,30) -> slot0 seg_n=7F, slot1 10, slot2 30, slot3 40. With LZ_SUPPRESS=0, slot0=40.
3. Change inputs from "1234" to "5678" during slot 1 of a frame -> the rest of that frame still shows 24,30,19; the next frame shows 12,02,78,00.
4. sound_alarm=1 with phase=0 -> buzzer=1, digits lit, dp_n=0 in slot 1 active cycles. After a one_second pulse -> buzzer=0, seg_n=7F, dp_n=1 in every slot, an_n still scanning.
5. Inputs 8'h20 and 8'h41 on any digit -> that slot seg_n=7F while its anode still asserts.
6. Assert reset mid-slot 2 -> in the same cycle (asynchronous) seg_n=7F, an_n=F, dp_n=1, buzzer=0. After release, a blank frame is shown again.
